prga_fifo_counted: RTL and testbench

- Parametrised successor to the single-depth FIFO: depth, data width and read mode (standard or lookahead) are all selectable.
- Adds occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Used as a general-purpose buffer between PRGA control and data-path blocks where back-pressure needs early warning.

---
 rtl/prga_fifo_counted.sv | 130 +++++++++++++
 tb/tb_prga_fifo_counted.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/prga_fifo_counted.sv
// Parametrised FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow flags and a standard or lookahead read port.
module prga_fifo_counted #(
   parameter int DATA_WIDTH         = 32,
   parameter int DEPTH_LOG2         = 4,
   parameter int LOOKAHEAD          = 0,
   parameter int ALMOST_FULL_THRES  = (2 ** DEPTH_LOG2) - 2,
   parameter int ALMOST_EMPTY_THRES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  empty,
   output logic                  almost_empty,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;

   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
   localparam cnt_t AF_C    = cnt_t'(ALMOST_FULL_THRES);
   localparam cnt_t AE_C    = cnt_t'(ALMOST_EMPTY_THRES);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   ptr_t                  wptr_q, wptr_d;
   ptr_t                  rptr_q, rptr_d;
   cnt_t                  count_q, count_d;
   logic                  full_q, empty_q, afull_q, aempty_q;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] head_s;
   logic                  wr_acc_s, rd_acc_s;

   // Next-state: acceptance, pointers, occupancy, output register, error flags
   always_comb begin
      wr_acc_s = wr & ~full_q;
      rd_acc_s = rd & ~empty_q;
      wptr_d   = wr_acc_s ? (wptr_q + ptr_t'(1)) : wptr_q;
      rptr_d   = rd_acc_s ? (rptr_q + ptr_t'(1)) : rptr_q;

      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase

      // The incoming word becomes the head when nothing older survives this cycle
      if (wr_acc_s && (count_q == (rd_acc_s ? cnt_t'(1) : cnt_t'(0)))) begin
         head_s = din;
      end else begin
         head_s = mem_q[rptr_d];
      end

      dout_d = dout_q;
      if (LOOKAHEAD != 0) begin
         if (count_d != cnt_t'(0)) begin
            dout_d = head_s;
         end else begin
            dout_d = dout_q;
         end
      end else begin
         if (rd_acc_s) begin
            dout_d = mem_q[rptr_q];
         end else begin
            dout_d = dout_q;
         end
      end

      // A new error event takes priority over a clear in the same cycle
      overflow_d  = (wr & full_q)  | (overflow_q  & ~clr_err);
      underflow_d = (rd & empty_q) | (underflow_q & ~clr_err);
   end

   // Control state and registered flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= ptr_t'(0);
         rptr_q      <= ptr_t'(0);
         count_q     <= cnt_t'(0);
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dout_q      <= {DATA_WIDTH{1'b0}};
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         full_q      <= (count_d == DEPTH_C);
         empty_q     <= (count_d == cnt_t'(0));
         afull_q     <= (count_d >= AF_C);
         aempty_q    <= (count_d <= AE_C);
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         dout_q      <= dout_d;
      end
   end

   // Storage array, written only on accepted writes
   always_ff @(posedge clk) begin
      if (wr_acc_s && !rst) begin
         mem_q[wptr_q] <= din;
      end
   end

   assign full         = full_q;
   assign almost_full  = afull_q;
   assign empty        = empty_q;
   assign almost_empty = aempty_q;
   assign dout         = dout_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_prga_fifo_counted.sv
// Bench for prga_fifo_counted: a standard-mode depth-4 instance and a lookahead
// depth-8 instance share one stimulus stream, each against a queue-based model.
module tb_prga_fifo_counted;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, wr, rd, clr_err;
   logic [7:0] din;

   logic       full_a, afull_a, empty_a, aempty_a, ovf_a, udf_a;
   logic [7:0] dout_a;
   logic [2:0] count_a;
   logic       full_b, afull_b, empty_b, aempty_b, ovf_b, udf_b;
   logic [7:0] dout_b;
   logic [3:0] count_b;

   prga_fifo_counted #(.DATA_WIDTH(8), .DEPTH_LOG2(2), .LOOKAHEAD(0)) dut_a (
      .clk(clk), .rst(rst), .full(full_a), .almost_full(afull_a), .wr(wr), .din(din),
      .empty(empty_a), .almost_empty(aempty_a), .rd(rd), .dout(dout_a), .count(count_a),
      .overflow(ovf_a), .underflow(udf_a), .clr_err(clr_err));

   prga_fifo_counted #(.DATA_WIDTH(8), .DEPTH_LOG2(3), .LOOKAHEAD(1),
                       .ALMOST_FULL_THRES(6), .ALMOST_EMPTY_THRES(2)) dut_b (
      .clk(clk), .rst(rst), .full(full_b), .almost_full(afull_b), .wr(wr), .din(din),
      .empty(empty_b), .almost_empty(aempty_b), .rd(rd), .dout(dout_b), .count(count_b),
      .overflow(ovf_b), .underflow(udf_b), .clr_err(clr_err));

   int n_err = 0;
   int n_chk = 0;
   bit armed = 1'b0;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] exp_a[$];
   logic [7:0] last_a;
   bit         m_ovf_a, m_udf_a, m_ovf_b, m_udf_b;

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model, standard mode depth 4: a popped word is expected on dout next
   always @(posedge clk) begin
      bit f, e;
      if (rst) begin
         qa.delete();
         exp_a.delete();
         m_ovf_a = 1'b0;
         m_udf_a = 1'b0;
         last_a  = 8'h00;
         armed   = 1'b1;
      end else begin
         f = (qa.size() == 4);
         e = (qa.size() == 0);
         if (rd && !e) begin
            last_a = qa.pop_front();
            exp_a.push_back(last_a);
         end
         if (wr && !f) qa.push_back(din);
         m_ovf_a = (wr && f) || (m_ovf_a && !clr_err);
         m_udf_a = (rd && e) || (m_udf_a && !clr_err);
      end
   end

   // Reference model, lookahead mode depth 8: dout must equal the queue head
   always @(posedge clk) begin
      bit f, e;
      if (rst) begin
         qb.delete();
         m_ovf_b = 1'b0;
         m_udf_b = 1'b0;
      end else begin
         f = (qb.size() == 8);
         e = (qb.size() == 0);
         if (rd && !e) void'(qb.pop_front());
         if (wr && !f) qb.push_back(din);
         m_ovf_b = (wr && f) || (m_ovf_b && !clr_err);
         m_udf_b = (rd && e) || (m_udf_b && !clr_err);
      end
   end

   // Monitor: compares every DUT output against the models between clock edges
   always @(negedge clk) begin
      if (armed) begin
         chk("countA",  count_a,  qa.size());
         chk("fullA",   full_a,   qa.size() == 4);
         chk("emptyA",  empty_a,  qa.size() == 0);
         chk("afullA",  afull_a,  qa.size() >= 2);
         chk("aemptyA", aempty_a, qa.size() <= 1);
         chk("ovfA",    ovf_a,    m_ovf_a);
         chk("udfA",    udf_a,    m_udf_a);
         if (exp_a.size() != 0) chk("doutA", dout_a, exp_a.pop_front());
         else                   chk("holdA", dout_a, last_a);

         chk("countB",  count_b,  qb.size());
         chk("fullB",   full_b,   qb.size() == 8);
         chk("emptyB",  empty_b,  qb.size() == 0);
         chk("afullB",  afull_b,  qb.size() >= 6);
         chk("aemptyB", aempty_b, qb.size() <= 2);
         chk("ovfB",    ovf_b,    m_ovf_b);
         chk("udfB",    udf_b,    m_udf_b);
         if (!empty_b && qb.size() != 0) chk("headB", dout_b, qb[0]);
      end
   end

   task automatic step(input bit rs, input bit w, input bit r, input logic [7:0] d, input bit c);
      rst = rs; wr = w; rd = r; din = d; clr_err = c;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] v[4];
      v = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00; clr_err = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Fill and drain the depth-4 FIFO
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, v[i], 1'b0);
      chk("tp1_cntA", count_a, 4);
      chk("tp1_fullA", full_a, 1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
         chk("tp1_doutA", dout_a, v[i]);
      end
      chk("tp1_emptyA", empty_a, 1);

      // Write while full with a simultaneous read
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, v[i], 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
      chk("tp2_ovfA", ovf_a, 1);
      chk("tp2_cntA", count_a, 3);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("tp2_clrA", ovf_a, 0);
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
         chk("tp2_doutA", dout_a, v[i]);
      end

      // Lookahead presentation and continuous streaming with pointer wrap
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'hA0, 1'b0);
      chk("tp3_emptyB", empty_b, 0);
      chk("tp3_doutB", dout_b, 8'hA0);
      step(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("tp3_popB", dout_b, 8'hA1);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1, 8'(i), 1'b0);
         chk("tp3_cntB", count_b, 1);
         chk("tp3_seqB", dout_b, i);
      end

      // Almost-flag thresholds on the depth-8 instance
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'(i + 8'h40), 1'b0);
         chk("tp4_aeB_fill", aempty_b, i <= 2);
         chk("tp4_afB_fill", afull_b, i >= 6);
      end
      for (int i = 7; i >= 0; i--) begin
         step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
         chk("tp4_aeB_drain", aempty_b, i <= 2);
         chk("tp4_afB_drain", afull_b, i >= 6);
      end

      // Underflow on empty, and write+read on empty
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("tp5_udfA", udf_a, 1);
      chk("tp5_cntA", count_a, 0);
      chk("tp5_doutA", dout_a, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
      chk("tp5_cntB", count_b, 1);
      chk("tp5_udfB", udf_b, 1);

      // Reset mid-operation discards contents
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(i + 8'h60), 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("tp6_cntB", count_b, 0);
      chk("tp6_emptyB", empty_b, 1);
      chk("tp6_ovfA", ovf_a, 0);
      step(1'b0, 1'b1, 1'b0, 8'h7E, 1'b0);
      chk("tp6_doutB", dout_b, 8'h7E);
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("tp6_doutA", dout_a, 8'h7E);

      // Randomised traffic: write-heavy phase, then read-heavy phase
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 249) == 0,
              $urandom_range(0, 99) < ((i < 1500) ? 65 : 35),
              $urandom_range(0, 99) < ((i < 1500) ? 35 : 65),
              8'($urandom),
              $urandom_range(0, 19) == 0);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
